// File: rtl/counter_share_ctrl.sv
// Round-robin controller sharing one up-counter between two requesters.
// Optional macro COUNTER_SHARE_ABORT_EN: dropping req[sel] mid-run aborts the run without done.
module counter_share_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             sel;
    logic             ptr;
    logic [WIDTH-1:0] target;
    logic             win;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb win = (req == 2'b11) ? ptr : req[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sel    <= 1'b0;
            ptr    <= 1'b0;
            target <= '0;
            gnt    <= 2'b00;
            busy   <= 1'b0;
            count  <= '0;
            done   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (req != 2'b00) begin
                        sel    <= win;
                        target <= win ? len1 : len0;
                        count  <= '0;
                        gnt    <= win ? 2'b10 : 2'b01;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
`ifdef COUNTER_SHARE_ABORT_EN
                    if (!req[sel]) begin
                        gnt   <= 2'b00;
                        busy  <= 1'b0;
                        ptr   <= ~sel;
                        state <= IDLE;
                    end else
`endif
                    if (count == target) begin
                        gnt   <= 2'b00;
                        done  <= sel ? 2'b10 : 2'b01;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    busy  <= 1'b0;
                    ptr   <= ~sel;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Randomized scoreboard bench for counter_share_ctrl against a run-window timing model.
module tb_counter_share_ctrl;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] len0, len1;
    logic [1:0]   gnt, done;
    logic         busy;
    logic [W-1:0] count;

    counter_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
        .gnt(gnt), .busy(busy), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sel;
        int   cyc;
        int   len;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: a run granted at edge g with length L owns edges g..g+L+2.
    int       cyc = 0;
    int       next_free = 0;
    int       g = 0;
    int       rl = 0;
    logic     rsel = 1'b0;
    logic     active = 1'b0;
    logic     ptr = 1'b0;
    int       last_count = 0;
    logic [1:0] exp_gnt = 2'b00;
    logic       exp_busy = 1'b0;
    int         exp_count = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            next_free = 0; active = 1'b0; ptr = 1'b0; last_count = 0;
            exp_gnt = 2'b00; exp_busy = 1'b0; exp_count = 0;
        end else begin
            cyc++;
            if (cyc >= next_free && req != 2'b00) begin
                rsel      = (req == 2'b11) ? ptr : (req == 2'b10);
                rl        = rsel ? int'(len1) : int'(len0);
                g         = cyc;
                active    = 1'b1;
                ptr       = ~rsel;
                next_free = cyc + rl + 3;
                q.push_back('{rsel, g + rl + 1, rl});
            end
`ifdef COUNTER_SHARE_ABORT_EN
            else if (active && cyc >= g + 1 && cyc <= g + rl + 1 && !req[rsel]) begin
                last_count = cyc - 1 - g;
                active     = 1'b0;
                next_free  = cyc + 1;
                void'(q.pop_back());
            end
`endif
            if (active && cyc <= g + rl) begin
                exp_gnt = rsel ? 2'b10 : 2'b01; exp_busy = 1'b1; exp_count = cyc - g;
            end else if (active && cyc == g + rl + 1) begin
                exp_gnt = 2'b00; exp_busy = 1'b1; exp_count = rl;
            end else begin
                if (active) begin
                    last_count = rl;
                    active     = 1'b0;
                end
                exp_gnt = 2'b00; exp_busy = 1'b0; exp_count = last_count;
            end
        end
    end

    // Monitor: level outputs every cycle, done pulses popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        chk("gnt", int'(gnt), int'(exp_gnt));
        chk("busy", int'(busy), int'(exp_busy));
        chk("count", int'(count), exp_count);
        if (done != 2'b00 || (q.size() > 0 && q[0].cyc == cyc)) begin
            if (q.size() == 0) begin
                chk("done_spurious", int'(done), 0);
            end else begin
                e = q.pop_front();
                chk("done_vec", int'(done), e.sel ? 2 : 1);
                chk("done_cyc", cyc, e.cyc);
                chk("done_count", int'(count), e.len);
            end
        end
    end

    initial begin
        logic hit;
        reset = 1'b0; req = 2'b00; len0 = '0; len1 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 3) == 0) req = 2'(unsigned'($urandom_range(0, 3)));
            len0 = W'(unsigned'($urandom_range(0, 7)));
            len1 = W'(unsigned'($urandom_range(0, 7)));
        end

        // Reset in the middle of a run, then a tie must go to requester 0.
        req = 2'b01; len0 = 3'd5; hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #2;
            if (exp_busy && exp_gnt == 2'b01 && exp_count == 2) hit = 1'b1;
        end
        chk("reset_wait", int'(hit), 1);
        reset = 1'b0;
        #1;
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk); #3;
        reset = 1'b1; req = 2'b11; len0 = 3'd1; len1 = 3'd2;
        @(posedge clk); #2;
        chk("post_rst_prio", int'(gnt), 1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 2) == 0) req = 2'(unsigned'($urandom_range(0, 3)));
            len0 = W'(unsigned'($urandom_range(0, 7)));
            len1 = W'(unsigned'($urandom_range(0, 7)));
        end

        req = 2'b00;
        repeat (15) @(posedge clk);
        #2;
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_share_ctrl.md
# counter_share_ctrl

Round-robin scheduler that shares one up-counter among two requesters. Each requester asks for a run of `len` counts. The controller grants the counter to one requester at a time, clears and advances the counter up to the requested length, then pulses a per-requester done. It sits between the requesting logic and the counter datapath, and owns the counter value and the grant.

## Interface
Parameters:
- `WIDTH`, default 3, counter and length width in bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; while 0, all state is forced to its reset value.
- `req`  in  2  level request, one bit per requester.
- `len0`  in  WIDTH  requested length for requester 0; sampled at grant.
- `len1`  in  WIDTH  requested length for requester 1; sampled at grant.
- `gnt`  out  2  one-hot grant, registered; reset 2'b00.
- `busy`  out  1  high in states RUN and DONE; reset 0.
- `count`  out  WIDTH  shared counter value; reset 0.
- `done`  out  2  one-cycle completion pulse, one-hot; reset 2'b00.

## Operation
States:
- IDLE (reset state)
  - If `req` ≠ 0: select the winner, latch `sel` and `target` = `len<sel>`, set `count`=0, `gnt[sel]`=1, go to RUN.
  - Otherwise: remain in IDLE. `count` holds its last value.
- RUN
  - If `count`==`target`: go to DONE.
  - Otherwise: `count` ← `count`+1.
- DONE
  - `done[sel]`=1 for this cycle only. `gnt`=0.
  - Update priority pointer so `sel` becomes lowest priority.
  - Go to IDLE.

Arbitration:
- Round-robin between the two requesters. After reset, requester 0 has priority.
- If only one requester is asserting, it wins regardless of the pointer.

Arithmetic and boundaries:
- Counting is unsigned. `count` stops at `target` and never wraps. The maximum length is 2^WIDTH−1 (7 at the default width).
- `len`=0: grant, then DONE on the next edge. `count` stays 0.
- `len0`/`len1` changes after grant are ignored; `target` is latched at grant.
- `req[sel]` held after `done`: the requester re-enters arbitration at the next IDLE. If the other requester is also asserting, the other side wins.
- Reset asserted mid-run: the controller immediately returns to IDLE and all outputs take their reset values. No `done` is issued.
- `gnt` and `done` are never both nonzero for different requesters in the same cycle.

## Timing
Let edge 1 be the first rising edge at which IDLE samples `req` ≠ 0.
- Edge 1: `gnt` asserted, `busy`=1, `count`=0.
- Edge 1+k, for k ≤ L: `count`=k.
- Edge 2+L: state DONE; `done` pulses, `gnt`=0.
- Edge 3+L: IDLE; `busy`=0, `count` holds L.
- Edge 4+L: earliest next grant.
- Total occupancy is L+3 cycles per run; there is no combinational path from inputs to outputs.

## Configuration
Macro: `COUNTER_SHARE_ABORT_EN`.
- Defined: if `req[sel]` falls during RUN, the next edge goes to IDLE.
  - `gnt`=0, no `done` pulse, pointer updated as for a completed run.
  - `count` holds the value reached.
- Undefined: `req` is ignored once granted; every run completes with `done`.

## Test plan
- Reset, then hold `req`=01 with `len0`=3 → `gnt`=01 at edge 1; `count` 0,1,2,3 at edges 1–4; `done`=01 for one cycle at edge 5; `busy`=0 at edge 6.
- `req`=11 held continuously, `len0`=2, `len1`=1 → grants alternate 01,10,01.
  - First `done`=01 at edge 4.
  - `gnt`=10 at edge 6; `done`=10 at edge 8.
- `req`=10, `len1`=0 → `gnt`=10 at edge 1, `done`=10 at edge 2, `count` stays 0.
- `len0`=7 → `count` reaches 7 at edge 8 and never wraps to 0; `done`=01 at edge 9.
- Assert `reset` low mid-run at `count`=2 → `gnt`, `done`, `count`, `busy` all 0 immediately; after release, requester 0 has priority again.
- With `COUNTER_SHARE_ABORT_EN` defined, drop `req[0]` at `count`=1 → `gnt`=00 on the next edge, no `done`, and a pending `req[1]` is granted two edges later.
